dcache: RTL and testbench



---
 rtl/dcache_pkg.sv | 49 ++++
 rtl/dcache_if.sv | 21 ++
 rtl/dcache_line_store.sv | 55 +++++
 rtl/dcache.sv | 201 ++++++++++++++++++++
 tb/tb_dcache.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: request encodings, FSM states,
// address-field width helpers and the byte-merge helper.
package dcache_pkg;

    localparam logic [1:0] DCACHE_IDLE  = 2'd0;
    localparam logic [1:0] DCACHE_READ  = 2'd1;
    localparam logic [1:0] DCACHE_WRITE = 2'd2;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Word-offset field width inside a line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever remains of the 30-bit word address.
    function automatic int tag_bits(input int lines, input int line_words);
        return 30 - $clog2(lines) - $clog2(line_words);
    endfunction

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Memory-unit <-> cache channel. The memory unit is the master; the cache
// sits on the slave modport.
interface mem_dcache_inf;
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        busy;
    logic        done;
    logic [31:0] read_data;

    modport master (
        output rw_flag, addr, write_data, write_mask,
        input  busy, done, read_data
    );

    modport slave (
        input  rw_flag, addr, write_data, write_mask,
        output busy, done, read_data
    );
endinterface

// File: rtl/dcache_line_store.sv
// Storage for the cache lines: valid bits, tags and data words. Lookup is
// combinational; word writes are byte-masked; valid/tag change per line.
import dcache_pkg::*;

module dcache_line_store #(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int IDX_W      = idx_bits(LINES),
    parameter int OFF_W      = off_bits(LINE_WORDS),
    parameter int TAG_W      = tag_bits(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [OFF_W-1:0] rd_off,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_word,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_mask,
    input  logic             upd_en,
    input  logic             upd_valid,
    input  logic [TAG_W-1:0] upd_tag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][LINE_WORDS];

    assign rd_valid = valid[idx];
    assign rd_tag   = tags[idx];
    assign rd_word  = data[idx][rd_off];

    // Valid bits are the only state that must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (upd_en) begin
            valid[idx] <= upd_valid;
        end
    end

    // Tag and data arrays are meaningless while the line is invalid.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tags[idx] <= upd_tag;
        end
        if (wr_en) begin
            data[idx][wr_off] <= merge_bytes(data[idx][wr_off], wr_data, wr_mask);
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache. One request at
// a time; misses refill a whole line in order, stores always go to memory.
import dcache_pkg::*;

module dcache #(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    mem_dcache_inf.slave bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, LINE_WORDS);

    state_t state, next_state;

    logic             req_is_read;
    logic [29:0]      req_word;
    logic [31:0]      req_data;
    logic [3:0]       req_mask;
    logic [OFF_W-1:0] beat;
    logic [31:0]      fill_word;
    logic [31:0]      read_q;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [31:0]      line_word;
    logic             hit;
    logic             last_beat;
    logic             accept;

    logic             st_wr_en;
    logic [OFF_W-1:0] st_wr_off;
    logic [31:0]      st_wr_data;
    logic [3:0]       st_wr_mask;
    logic             st_upd_en;
    logic             st_upd_valid;

    assign req_off   = req_word[OFF_W-1:0];
    assign req_idx   = req_word[OFF_W +: IDX_W];
    assign req_tag   = req_word[29 -: TAG_W];
    assign hit       = line_valid && (line_tag == req_tag);
    assign last_beat = (beat == OFF_W'(LINE_WORDS - 1));
    assign accept    = (state == ST_IDLE) &&
                       ((bus.rw_flag == DCACHE_READ) || (bus.rw_flag == DCACHE_WRITE));

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_RESP);
    assign bus.read_data = read_q;

    dcache_line_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .idx       (req_idx),
        .rd_off    (req_off),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_word   (line_word),
        .wr_en     (st_wr_en),
        .wr_off    (st_wr_off),
        .wr_data   (st_wr_data),
        .wr_mask   (st_wr_mask),
        .upd_en    (st_upd_en),
        .upd_valid (st_upd_valid),
        .upd_tag   (req_tag)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, memory-port drive and line-store write controls.
    always_comb begin
        next_state   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wmask    = '0;
        st_wr_en     = 1'b0;
        st_wr_off    = req_off;
        st_wr_data   = req_data;
        st_wr_mask   = req_mask;
        st_upd_en    = 1'b0;
        st_upd_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (req_is_read) begin
                    if (hit) begin
                        next_state = ST_RESP;
                    end else begin
                        // Invalidate before overwriting so a partial fill never hits.
                        st_upd_en    = 1'b1;
                        st_upd_valid = 1'b0;
                        next_state   = ST_REFILL;
                    end
                end else begin
                    st_wr_en   = hit;
                    next_state = ST_WRITE;
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, beat, 2'b00};
                if (mem_ack) begin
                    st_wr_en   = 1'b1;
                    st_wr_off  = beat;
                    st_wr_data = mem_rdata;
                    st_wr_mask = 4'hF;
                    if (last_beat) begin
                        st_upd_en    = 1'b1;
                        st_upd_valid = 1'b1;
                        next_state   = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {req_word, 2'b00};
                mem_wdata = req_data;
                mem_wmask = req_mask;
                if (mem_ack) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch, refill beat counter and the returned load word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_is_read <= 1'b0;
            req_word    <= '0;
            req_data    <= '0;
            req_mask    <= '0;
            beat        <= '0;
            fill_word   <= '0;
            read_q      <= '0;
        end else begin
            if (accept) begin
                req_is_read <= (bus.rw_flag == DCACHE_READ);
                req_word    <= bus.addr[31:2];
                req_data    <= bus.write_data;
                req_mask    <= bus.write_mask;
            end
            if (state == ST_LOOKUP) begin
                beat <= '0;
                if (req_is_read && hit) begin
                    read_q <= line_word;
                end
            end
            if ((state == ST_REFILL) && mem_ack) begin
                beat <= beat + OFF_W'(1);
                if (beat == req_off) begin
                    fill_word <= mem_rdata;
                end
                if (last_beat) begin
                    read_q <= (beat == req_off) ? mem_rdata : fill_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: each request pushes its expected outcome,
// which is popped and compared when the cache signals done.
import dcache_pkg::*;

module tb_dcache;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          beats;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    beat_t       log_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          ws = 0;
    int          wait_cnt = 0;
    bit          held = 0;
    logic [31:0] held_addr = '0;
    int          unstable = 0;

    mem_dcache_inf bus();

    dcache #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat(a);
    endfunction

    // Memory model: ack and data are set up on the falling edge.
    always @(negedge clk) begin
        mem_ack   = mem_req && (wait_cnt == ws);
        mem_rdata = mem_read(mem_addr);
    end

    // Memory model: consume beats on the rising edge, track address stability.
    always @(posedge clk) begin
        if (mem_req && held && (mem_addr !== held_addr)) unstable++;
        if (mem_req && mem_ack) begin
            log_q.push_back('{mem_addr, mem_we, mem_wdata, mem_wmask});
            if (mem_we) begin
                logic [31:0] w;
                w = mem_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                mem_model[mem_addr] = w;
            end
            wait_cnt = 0;
            held     = 0;
        end else if (mem_req) begin
            held      = 1;
            held_addr = mem_addr;
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            held     = 0;
        end
    end

    task automatic do_req(input logic [1:0] flag, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm,
                          input logic [31:0] exp_data, input int exp_lat,
                          input int exp_beats, input bit noise, input string name);
        exp_t e;
        int   beats0;
        int   cyc;
        @(negedge clk);
        bus.rw_flag    = flag;
        bus.addr       = a;
        bus.write_data = wd;
        bus.write_mask = wm;
        @(posedge clk);
        beats0 = log_q.size();
        exp_q.push_back('{exp_data, exp_lat, exp_beats});
        #1 bus.rw_flag = DCACHE_IDLE;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (noise) begin
                bus.rw_flag = (cyc >= 2 && cyc <= 10 && cyc[0]) ? DCACHE_READ : DCACHE_IDLE;
                bus.addr    = 32'h0000_0500;
            end
        end while (!bus.done && cyc < 200);
        bus.rw_flag = DCACHE_IDLE;
        e = exp_q.pop_front();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s done timeout: got %b want 1", name, bus.done);
        end
        checks++;
        if (cyc != e.lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        checks++;
        if (bus.read_data !== e.data) begin
            errors++;
            $display("[TB] FAIL %s read_data: got %h want %h", name, bus.read_data, e.data);
        end
        checks++;
        if (log_q.size() - beats0 != e.beats) begin
            errors++;
            $display("[TB] FAIL %s beats: got %0d want %0d", name, log_q.size() - beats0, e.beats);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, mem_req, mem_we} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset flags: got %b want 0000", {bus.busy, bus.done, mem_req, mem_we});
        end
        checks++;
        if ({bus.read_data, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            errors++;
            $display("[TB] FAIL reset buses: got %h %h %h %h want 0", bus.read_data, mem_addr, mem_wdata, mem_wmask);
        end
        rst = 1'b1;
    endtask

    task automatic test_read_miss_hit();
        int b0;
        b0 = log_q.size();
        do_req(DCACHE_READ, 32'h104, '0, '0, 32'hDEAD_BEEF, 6, 4, 0, "read_miss");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_q[b0+i].addr !== 32'h100 + 32'(4*i) || log_q[b0+i].we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL refill_beat%0d: got %h we=%b want %h we=0", i, log_q[b0+i].addr, log_q[b0+i].we, 32'h100 + 32'(4*i));
            end
        end
        do_req(DCACHE_READ, 32'h104, '0, '0, 32'hDEAD_BEEF, 2, 0, 0, "read_hit");
    endtask

    task automatic test_write_hit_merge();
        beat_t w;
        do_req(DCACHE_WRITE, 32'h104, 32'h0000_AB00, 4'b0010, 32'hDEAD_BEEF, 3, 1, 0, "write_hit");
        w = log_q[log_q.size()-1];
        checks++;
        if (w.addr !== 32'h104 || w.we !== 1'b1 || w.wmask !== 4'b0010 || w.wdata !== 32'h0000_AB00) begin
            errors++;
            $display("[TB] FAIL write_hit_beat: got %h we=%b m=%b d=%h want 104 we=1 m=0010 d=0000ab00", w.addr, w.we, w.wmask, w.wdata);
        end
        do_req(DCACHE_READ, 32'h104, '0, '0, 32'hDEAD_ABEF, 2, 0, 0, "merged_read");
    endtask

    task automatic test_write_miss();
        do_req(DCACHE_WRITE, 32'h2000, 32'h1234_5678, 4'hF, 32'hDEAD_ABEF, 3, 1, 0, "write_miss");
        do_req(DCACHE_READ, 32'h2000, '0, '0, 32'h1234_5678, 6, 4, 0, "read_after_wmiss");
    endtask

    task automatic test_conflict();
        do_req(DCACHE_READ, 32'h100,  '0, '0, pat(32'h100),  6, 4, 0, "conflict_a");
        do_req(DCACHE_READ, 32'h1100, '0, '0, pat(32'h1100), 6, 4, 0, "conflict_b");
        do_req(DCACHE_READ, 32'h100,  '0, '0, pat(32'h100),  6, 4, 0, "conflict_a2");
    endtask

    task automatic test_wait_states();
        int b0;
        int extra;
        ws = 3;
        unstable = 0;
        b0 = log_q.size();
        do_req(DCACHE_READ, 32'h340, '0, '0, pat(32'h340), 18, 4, 1, "wait_read");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_q[b0+i].addr !== 32'h340 + 32'(4*i)) begin
                errors++;
                $display("[TB] FAIL wait_beat%0d: got %h want %h", i, log_q[b0+i].addr, 32'h340 + 32'(4*i));
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("[TB] FAIL mem_addr_stable: got %0d changes want 0", unstable);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("[TB] FAIL ignored_request: got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid_refill();
        int b0;
        int cyc;
        ws = 1;
        b0 = log_q.size();
        @(negedge clk);
        bus.rw_flag = DCACHE_READ;
        bus.addr    = 32'h600;
        @(posedge clk);
        exp_q.push_back('{pat(32'h600), 10, 4});
        #1 bus.rw_flag = DCACHE_IDLE;
        cyc = 0;
        while (log_q.size() - b0 < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (log_q.size() - b0 != 2) begin
            errors++;
            $display("[TB] FAIL mid_refill_beats: got %0d want 2", log_q.size() - b0);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, mem_req, mem_we} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset flags: got %b want 0000", {bus.busy, bus.done, mem_req, mem_we});
        end
        checks++;
        if ({bus.read_data, mem_addr, mem_wdata, mem_wmask} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset buses: got %h %h %h %h want 0", bus.read_data, mem_addr, mem_wdata, mem_wmask);
        end
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(DCACHE_READ, 32'h600, '0, '0, pat(32'h600), 10, 4, 0, "refill_after_reset");
    endtask

    initial begin
        bus.rw_flag    = DCACHE_IDLE;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.write_mask = '0;
        mem_model[32'h104] = 32'hDEAD_BEEF;
        test_reset();
        test_read_miss_hit();
        test_write_hit_merge();
        test_write_miss();
        test_conflict();
        test_wait_states();
        test_reset_mid_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
